// File: rtl/tdp_fifo_pkg.sv
// tdp_fifo_pkg: shared types and constants for the TDP-RAM FIFO controller.
// Holds the output-stage state encoding and the occupancy limit of the
// prefetch stage (fetch in flight + head + skid).
package tdp_fifo_pkg;

  // Output-stage occupancy; fetch_pending is tracked separately.
  typedef enum logic [1:0] {
    OS_EMPTY     = 2'd0,
    OS_HEAD      = 2'd1,
    OS_HEAD_SKID = 2'd2
  } os_state_t;

  // Maximum words held or in flight between the RAM and the consumer.
  localparam int OC_MAX = 2;

  // Number of words physically held in head/skid for a given state.
  function automatic logic [1:0] os_words(input os_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      OS_HEAD:      n = 2'd1;
      OS_HEAD_SKID: n = 2'd2;
      default:      n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tdp_fifo_ctrl_if.sv
// tdp_fifo_ctrl_if: producer/consumer side of the FIFO controller.
// The optional almost_full/almost_empty flags exist only when
// TDP_FIFO_ALMOST_FLAGS_EN is defined.
interface tdp_fifo_ctrl_if #(
  parameter int ABITS = 10,
  parameter int DBITS = 36
) ();

  logic             push;
  logic [DBITS-1:0] wdata;
  logic             full;
  logic             pop;
  logic [DBITS-1:0] rdata;
  logic             empty;
  logic [ABITS:0]   count;
`ifdef TDP_FIFO_ALMOST_FLAGS_EN
  logic             almost_full;
  logic             almost_empty;

  // User side: issues push/pop, observes status and head data.
  modport master (
    output push, wdata, pop,
    input  full, rdata, empty, count, almost_full, almost_empty
  );

  // Controller side.
  modport slave (
    input  push, wdata, pop,
    output full, rdata, empty, count, almost_full, almost_empty
  );
`else
  // User side: issues push/pop, observes status and head data.
  modport master (
    output push, wdata, pop,
    input  full, rdata, empty, count
  );

  // Controller side.
  modport slave (
    input  push, wdata, pop,
    output full, rdata, empty, count
  );
`endif

endinterface

// File: rtl/tdp_fifo_outstage.sv
// tdp_fifo_outstage: first-word-fall-through output stage.
// Holds the head and skid registers, tracks the fetch returning from the
// RAM read port, and reports its occupancy (fetch + head + skid) as oc.
module tdp_fifo_outstage
  import tdp_fifo_pkg::*;
#(
  parameter int DBITS = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,   // read issued to the RAM this cycle
  input  logic             pop,     // accepted pop (already gated by !empty)
  input  logic [DBITS-1:0] rd_b,    // registered RAM read data
  output logic [DBITS-1:0] rdata,
  output logic             empty,
  output logic [1:0]       oc
);

  os_state_t        state_q, state_d;
  logic             fetch_pending;
  logic [DBITS-1:0] head_q, skid_q;
  logic             ld_head_rd, ld_head_skid, ld_skid;

  // State register and fetch tracking; the RAM answers one cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= OS_EMPTY;
      fetch_pending <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q       <= state_d;
      fetch_pending <= issue;
    end
  end

  // Next state and load strobes: returning data goes to head when it is
  // free or being popped, otherwise into the skid register.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    ld_head_rd   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      OS_EMPTY: begin
        if (fetch_pending) begin
          ld_head_rd = 1'b1;
          state_d    = OS_HEAD;
        end
      end
      OS_HEAD: begin
        if (pop) begin
          if (fetch_pending) ld_head_rd = 1'b1;
          else               state_d    = OS_EMPTY;
        end else if (fetch_pending) begin
          ld_skid = 1'b1;
          state_d = OS_HEAD_SKID;
        end
      end
      OS_HEAD_SKID: begin
        // Issue throttling keeps a fetch from landing here, but the pair
        // is still handled consistently if it ever does.
        if (pop) begin
          ld_head_skid = 1'b1;
          if (fetch_pending) ld_skid = 1'b1;
          else               state_d = OS_HEAD;
        end
      end
      default: state_d = OS_EMPTY;
    endcase
  end

  // Head/skid data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these few data registers are reset because rdata has a
      // defined reset value; the RAM array itself is never reset.
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_head_rd)        head_q <= rd_b;
      else if (ld_head_skid) head_q <= skid_q;
      if (ld_skid)           skid_q <= rd_b;
    end
  end

  assign rdata = head_q;
  assign empty = (state_q == OS_EMPTY);
  assign oc    = os_words(state_q) + {1'b0, fetch_pending};

endmodule

// File: rtl/tdp_fifo_ctrl.sv
// tdp_fifo_ctrl: synchronous FIFO controller driving an external
// true-dual-port RAM (port A writes, port B reads) with a prefetching
// first-word-fall-through output stage. Reads are only issued while
// unfetched words exist, so port A and port B never address the same word
// in a cycle where both are active.
// Optional feature: define TDP_FIFO_ALMOST_FLAGS_EN to add registered
// almost_full / almost_empty flags on the interface.
module tdp_fifo_ctrl
  import tdp_fifo_pkg::*;
#(
  parameter int ABITS    = 10,
  parameter int DBITS    = 36,
  parameter int DEPTH    = 1024,       // must equal 2**ABITS
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst,
  tdp_fifo_ctrl_if.slave   fifo,
  output logic [ABITS-1:0] ram_a_a,
  output logic [DBITS-1:0] ram_wd_a,
  output logic             ram_we_a,
  output logic [ABITS-1:0] ram_a_b,
  output logic             ram_we_b,
  input  logic [DBITS-1:0] ram_rd_b
);

  localparam logic [ABITS-1:0] PTR_ONE = 1;
  localparam logic [ABITS:0]   CNT_ONE = 1;
  localparam logic [ABITS:0]   CNT_MAX = (ABITS+1)'(DEPTH);

  logic [ABITS-1:0] wptr, rptr;
  logic [ABITS:0]   ram_cnt, ram_cnt_next;
  logic [ABITS:0]   cnt_q, cnt_next;
  logic             full_q;
  logic             push_acc, pop_acc, issue;
  logic [1:0]       oc;
  logic             os_empty;
  logic [DBITS-1:0] os_rdata;

  assign push_acc = fifo.push && !full_q;
  assign pop_acc  = fifo.pop && !os_empty;

  // Issue a read when unfetched words exist and the output stage will have
  // room after this cycle's pop (pop_acc implies oc >= 1, so no underflow).
  assign issue = (ram_cnt != '0) && ((oc - {1'b0, pop_acc}) < 2'(OC_MAX));

  // Next values of the unfetched-word count and the total count.
  always_comb begin
    ram_cnt_next = ram_cnt;
    if (push_acc && !issue)      ram_cnt_next = ram_cnt + CNT_ONE;
    else if (!push_acc && issue) ram_cnt_next = ram_cnt - CNT_ONE;

    cnt_next = cnt_q;
    if (push_acc && !pop_acc)      cnt_next = cnt_q + CNT_ONE;
    else if (!push_acc && pop_acc) cnt_next = cnt_q - CNT_ONE;
  end

  // Pointers, counters and the registered full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + PTR_ONE;
      if (issue)    rptr <= rptr + PTR_ONE;
      ram_cnt <= ram_cnt_next;
      cnt_q   <= cnt_next;
      full_q  <= (cnt_next == CNT_MAX);
    end
  end

`ifdef TDP_FIFO_ALMOST_FLAGS_EN
  localparam logic [ABITS:0] AF_THR = (ABITS+1)'(AF_LEVEL);
  localparam logic [ABITS:0] AE_THR = (ABITS+1)'(AE_LEVEL);

  logic af_q, ae_q;

  // Registered threshold flags, computed from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (cnt_next >= AF_THR);
      ae_q <= (cnt_next <= AE_THR);
    end
  end

  assign fifo.almost_full  = af_q;
  assign fifo.almost_empty = ae_q;
`endif

  tdp_fifo_outstage #(
    .DBITS (DBITS)
  ) u_outstage (
    .clk   (clk),
    .rst   (rst),
    .issue (issue),
    .pop   (pop_acc),
    .rd_b  (ram_rd_b),
    .rdata (os_rdata),
    .empty (os_empty),
    .oc    (oc)
  );

  assign fifo.full  = full_q;
  assign fifo.empty = os_empty;
  assign fifo.count = cnt_q;
  assign fifo.rdata = os_rdata;

  assign ram_a_a  = wptr;
  assign ram_wd_a = fifo.wdata;
  assign ram_we_a = push_acc;
  assign ram_a_b  = rptr;
  assign ram_we_b = 1'b0;

endmodule

// File: tb/tb_tdp_fifo_ctrl.sv
// tb_tdp_fifo_ctrl: directed bench for tdp_fifo_ctrl paired with a
// behavioural true-dual-port RAM (registered port-B read, 1-cycle latency).
module tb_tdp_fifo_ctrl;

  localparam int ABITS = 10;
  localparam int DBITS = 36;
  localparam int DEPTH = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ABITS-1:0] ram_a_a, ram_a_b;
  logic [DBITS-1:0] ram_wd_a, ram_rd_b;
  logic             ram_we_a, ram_we_b;

  int checks   = 0;
  int failures = 0;

  tdp_fifo_ctrl_if #(.ABITS(ABITS), .DBITS(DBITS)) fifo_if ();

  tdp_fifo_ctrl #(
    .ABITS (ABITS),
    .DBITS (DBITS),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fifo     (fifo_if),
    .ram_a_a  (ram_a_a),
    .ram_wd_a (ram_wd_a),
    .ram_we_a (ram_we_a),
    .ram_a_b  (ram_a_b),
    .ram_we_b (ram_we_b),
    .ram_rd_b (ram_rd_b)
  );

  always #5 clk = ~clk;

  // Behavioural TDP RAM: port A writes, port B reads every cycle.
  logic [DBITS-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_a_a] <= ram_wd_a;
    ram_rd_b <= mem[ram_a_b];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int               model_count;
    logic [DBITS-1:0] sb [$];
    logic [DBITS-1:0] w, exp_d;
    logic             do_push, do_pop, full_m, prev_we, got;
    logic [ABITS-1:0] prev_a, prev_b;

    fifo_if.push  = 1'b0;
    fifo_if.pop   = 1'b0;
    fifo_if.wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_empty", fifo_if.empty, 1);
    check("rst_full",  fifo_if.full,  0);
    check("rst_count", fifo_if.count, 0);
    check("rst_rdata", fifo_if.rdata, 0);
    check("rst_we_b",  ram_we_b,      0);
    rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_empty", fifo_if.empty, 1);
      check("idle_full",  fifo_if.full,  0);
      check("idle_count", fifo_if.count, 0);
      check("idle_we_a",  ram_we_a,      0);
    end

    // Single push of 0x5A, first-word latency
    fifo_if.push  = 1'b1;
    fifo_if.wdata = 36'h5A;
    #1;
    check("single_we_a", ram_we_a, 1);
    check("single_a_a",  ram_a_a,  0);
    check("single_wd_a", ram_wd_a, 36'h5A);
    tick();                                   // E0
    fifo_if.push = 1'b0;
    check("e0_empty", fifo_if.empty, 1);
    check("e0_count", fifo_if.count, 1);
    tick();                                   // E1
    check("e1_empty", fifo_if.empty, 1);
    check("e1_a_b",   ram_a_b,       1);
    tick();                                   // E2
    check("e2_empty", fifo_if.empty, 0);
    check("e2_rdata", fifo_if.rdata, 36'h5A);
    check("e2_count", fifo_if.count, 1);
    fifo_if.pop = 1'b1;
    tick();
    fifo_if.pop = 1'b0;
    check("single_pop_empty", fifo_if.empty, 1);
    check("single_pop_count", fifo_if.count, 0);

    // Fill to DEPTH with an incrementing pattern (wptr starts at 1)
    for (int i = 0; i < DEPTH; i++) begin
      fifo_if.push  = 1'b1;
      fifo_if.wdata = DBITS'(i);
      tick();
      if (i == DEPTH - 2) begin
        check("fill_1023_full",  fifo_if.full,  0);
        check("fill_1023_count", fifo_if.count, DEPTH - 1);
      end
    end
    check("fill_full",  fifo_if.full,  1);
    check("fill_count", fifo_if.count, DEPTH);
    check("fill_rdata", fifo_if.rdata, 0);

    // Extra push while full is ignored
    fifo_if.wdata = 36'hDEAD;
    #1;
    check("xpush_we_a", ram_we_a, 0);
    check("xpush_a_a",  ram_a_a,  1);
    tick();
    check("xpush_a_a_after", ram_a_a,       1);
    check("xpush_count",     fifo_if.count, DEPTH);
    check("xpush_rdata",     fifo_if.rdata, 0);

    // Push and pop together at full: pop accepted, push rejected
    fifo_if.pop = 1'b1;
    #1;
    check("fullpp_we_a", ram_we_a, 0);
    tick();
    fifo_if.push = 1'b0;
    check("fullpp_count", fifo_if.count, DEPTH - 1);
    check("fullpp_full",  fifo_if.full,  0);

    // Drain with pop held high: one word per cycle, in order
    for (int i = 1; i < DEPTH; i++) begin
      check("drain_empty", fifo_if.empty, 0);
      check("drain_rdata", fifo_if.rdata, DBITS'(i));
      tick();
    end
    check("drained_empty", fifo_if.empty, 1);
    check("drained_count", fifo_if.count, 0);

    // Pop while empty changes nothing
    tick();
    fifo_if.pop = 1'b0;
    check("epop_empty", fifo_if.empty, 1);
    check("epop_count", fifo_if.count, 0);
    check("epop_rdata", fifo_if.rdata, DBITS'(DEPTH - 1));
    check("epop_a_b",   ram_a_b,       1);

    // Random push/pop against a scoreboard
    model_count = 0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_count", fifo_if.count, model_count);
      check("rnd_full",  fifo_if.full,  model_count == DEPTH);
      do_push = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 35));
      do_pop  = ($urandom_range(0, 99) < ((c < 1500) ? 35 : 70));
      w = DBITS'({$urandom(), $urandom()});
      full_m = (model_count == DEPTH);
      if (do_pop && !fifo_if.empty) begin
        exp_d = (sb.size() != 0) ? sb[0] : {DBITS{1'bx}};
        check("rnd_rdata_x", $isunknown(fifo_if.rdata), 0);
        check("rnd_rdata",   fifo_if.rdata, exp_d);
        if (sb.size() != 0) void'(sb.pop_front());
        model_count--;
      end
      if (do_push && !full_m) begin
        sb.push_back(w);
        model_count++;
      end
      fifo_if.push  = do_push;
      fifo_if.pop   = do_pop;
      fifo_if.wdata = w;
      #1;
      prev_we = ram_we_a;
      prev_a  = ram_a_a;
      prev_b  = ram_a_b;
      tick();
      if (prev_we && (ram_a_b != prev_b))
        check("rnd_collision", prev_a == prev_b, 0);
    end
    fifo_if.push = 1'b0;

    // Drain the scoreboard, bounded
    fifo_if.pop = 1'b1;
    for (int c = 0; c < DEPTH + 16 && sb.size() != 0; c++) begin
      if (!fifo_if.empty) begin
        check("rnd_drain_rdata", fifo_if.rdata, sb[0]);
        void'(sb.pop_front());
      end
      tick();
    end
    fifo_if.pop = 1'b0;
    tick();
    check("rnd_drain_left",  sb.size(),     0);
    check("rnd_drain_count", fifo_if.count, 0);
    check("rnd_drain_empty", fifo_if.empty, 1);

    // Async reset mid-drain with a fetch in flight
    for (int i = 0; i < 8; i++) begin
      fifo_if.push  = 1'b1;
      fifo_if.wdata = DBITS'(16'h100 + i);
      tick();
    end
    fifo_if.push = 1'b0;
    tick();
    tick();
    fifo_if.pop = 1'b1;
    tick();
    tick();
    check("pre_rst_rdata", fifo_if.rdata, 36'h102);
    #2 rst = 1'b1;
    #1;
    check("arst_empty", fifo_if.empty, 1);
    check("arst_full",  fifo_if.full,  0);
    check("arst_count", fifo_if.count, 0);
    check("arst_rdata", fifo_if.rdata, 0);
    check("arst_a_a",   ram_a_a,       0);
    check("arst_a_b",   ram_a_b,       0);
    @(negedge clk);
    fifo_if.pop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fifo_if.push  = 1'b1;
    fifo_if.wdata = 36'h33;
    tick();
    fifo_if.push = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (!fifo_if.empty) got = 1'b1;
      else tick();
    end
    check("post_rst_seen",  got,           1);
    check("post_rst_rdata", fifo_if.rdata, 36'h33);
    check("post_rst_count", fifo_if.count, 1);
    fifo_if.pop = 1'b1;
    tick();
    fifo_if.pop = 1'b0;
    check("post_rst_empty", fifo_if.empty, 1);
    check("post_rst_count0", fifo_if.count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
